// File: rtl/grid_tile_cfg_chain.sv
// Configuration-chain controller for a physical tile: serial shift chain with
// pass-through, shadow commit on cfg_done rising edge, and output gating.
module grid_tile_cfg_chain #(
    parameter int NUM_SUBTILE      = 1,
    parameter int BITS_PER_SUBTILE = 64,
    parameter int NUM_O            = 10,
    localparam int T               = NUM_SUBTILE * BITS_PER_SUBTILE,
    localparam int CNT_W           = $clog2(T + 1)
) (
    input  logic             prog_clk,
    input  logic             prog_reset,
    input  logic             cfg_en,
    input  logic             ccff_head,
    input  logic             cfg_done,
    input  logic [NUM_O-1:0] tile_o_in,
    output logic             ccff_tail,
    output logic [T-1:0]     cfg_bits,
    output logic             cfg_valid,
    output logic             chain_full,
    output logic             cfg_error,
    output logic [CNT_W-1:0] shift_count,
    output logic [NUM_O-1:0] tile_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FULL   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_e;

    // A one-bit chain is full after its first shift, so SHIFT is skipped.
    localparam bit ONE_BIT_CHAIN = (T == 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(T);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T - 1);

    state_e           state_q, state_d;
    logic [T-1:0]     sreg_q, sreg_d;
    logic [T-1:0]     shadow_q, shadow_d;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             err_q, err_d;

    logic             shift_s;
    logic             rise_s;

    // cfg_done blocks shifting so a commit always sees a stable chain.
    assign shift_s = cfg_en & ~cfg_done;
    assign rise_s  = cfg_done & ~done_q;

    // State register.
    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ACTIVE: begin
                if (shift_s) begin
                    state_d = ONE_BIT_CHAIN ? ST_FULL : ST_SHIFT;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SHIFT: begin
                if (shift_s && (cnt_q == CNT_LAST)) begin
                    state_d = ST_FULL;
                end else if (rise_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_FULL: begin
                if (rise_s) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: chain shift, counter, flags and shadow commit.
    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        full_d   = full_q;
        err_d    = err_q;
        if (shift_s) begin
            sreg_d = (sreg_q << 1) | T'(ccff_head);
        end else begin
            sreg_d = sreg_q;
        end
        case (state_q)
            ST_IDLE, ST_ACTIVE: begin
                if (shift_s) begin
                    cnt_d  = CNT_W'(1);
                    full_d = ONE_BIT_CHAIN;
                end else if (rise_s && (state_q == ST_IDLE)) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end
            ST_SHIFT: begin
                if (shift_s) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        full_d = 1'b1;
                    end else begin
                        full_d = full_q;
                    end
                end else if (rise_s) begin
                    err_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_FULL: begin
                if (rise_s) begin
                    shadow_d = sreg_q;
                    valid_d  = 1'b1;
                    err_d    = 1'b0;
                    full_d   = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d  = CNT_FULL;
                    full_d = 1'b1;
                end
            end
            default: begin
                cnt_d  = '0;
                full_d = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            sreg_q   <= '0;
            shadow_q <= '0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sreg_q   <= sreg_d;
            shadow_q <= shadow_d;
            done_q   <= cfg_done;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            err_q    <= err_d;
        end
    end

    assign ccff_tail   = sreg_q[T-1];
    assign cfg_bits    = shadow_q;
    assign cfg_valid   = valid_q;
    assign chain_full  = full_q;
    assign cfg_error   = err_q;
    assign shift_count = cnt_q;
    assign tile_o      = tile_o_in & {NUM_O{valid_q}};

endmodule

// File: doc/grid_tile_cfg_chain.md
Name: grid_tile_cfg_chain

Overview:
- Parametrised configuration-chain controller for a generalised physical tile with NUM_SUBTILE subtiles of BITS_PER_SUBTILE config bits each.
- Shifts the bitstream in from ccff_head, passes it through to ccff_tail for downstream tiles, and commits a shadow copy on the rising edge of cfg_done.
- Gates tile outputs to 0 until a valid configuration is committed.
- Supports reconfiguration without dropping the active configuration.

Parameters:
- NUM_SUBTILE, 1, number of subtiles in the tile.
- BITS_PER_SUBTILE, 64, config bits per subtile.
- NUM_O, 10, number of tile output pins gated by cfg_valid.
- Derived (localparam, not overridable): T = NUM_SUBTILE*BITS_PER_SUBTILE; CNT_W = $clog2(T+1).

Ports:
- prog_clk  in  1  configuration clock; the block's only clock.
- prog_reset  in  1  asynchronous, active-low reset.
- cfg_en  in  1  shift enable; one chain bit per cycle while high.
- ccff_head  in  1  serial config data in.
- cfg_done  in  1  end-of-configuration strobe; rising edge commits.
- tile_o_in  in  NUM_O  raw outputs from the tile logic.
- ccff_tail  out  1  serial data out, equal to sreg[T-1].
- cfg_bits  out  T  committed configuration, with cfg_bits[i] = shadow[i].
- cfg_valid  out  1  committed configuration is in effect.
- chain_full  out  1  T bits shifted since the last start.
- cfg_error  out  1  sticky flag: commit attempted with an incomplete chain.
- shift_count  out  CNT_W  bits shifted, saturating at T.
- tile_o  out  NUM_O  tile_o_in when cfg_valid=1, else all zero; combinational AND.

Behaviour:
- Reset (prog_reset=0, asynchronous, effective immediately):
  - sreg, shadow, cfg_done_q, shift_count, cfg_valid, chain_full and cfg_error all go to 0.
  - State goes to IDLE; ccff_tail=0 and tile_o=0.
- Shift register:
  - On a prog_clk edge with cfg_en=1 and cfg_done=0: sreg[0]<=ccff_head and sreg[i]<=sreg[i-1].
  - The first bit shifted in reaches sreg[T-1] after T shifts.
  - cfg_en is ignored whenever cfg_done=1, so a commit never races a shift.
- Edge detect: cfg_done_q is cfg_done registered; rise = cfg_done & ~cfg_done_q.
- State IDLE:
  - cfg_en=1: shift, shift_count<=1, go to SHIFT.
  - rise: cfg_error<=1, stay in IDLE.
  - If T=1, the first shift goes directly to FULL.
- State SHIFT:
  - Each shift increments shift_count.
  - The shift that makes shift_count=T goes to FULL and sets chain_full<=1 on the same edge.
  - rise with shift_count<T: cfg_error<=1, shift_count<=0, go to IDLE; shadow and cfg_valid are unchanged.
- State FULL:
  - Further shifts are legal pass-through: shift_count stays at T and chain_full stays 1.
  - rise: shadow<=sreg (the value before this edge), cfg_valid<=1, cfg_error<=0, chain_full<=0, shift_count<=0, go to ACTIVE.
  - Commit latency: cfg_bits and cfg_valid update on the edge where the rise is sampled.
- State ACTIVE:
  - cfg_done falling has no effect.
  - cfg_en=1 starts reconfiguration: shift, shift_count<=1, go to SHIFT.
  - During reconfiguration cfg_valid stays 1 and cfg_bits holds the old configuration until the next successful commit.
  - A failed commit during reconfiguration keeps the old configuration valid and sets cfg_error.
  - rise in ACTIVE without shifts: ignored.
- sreg is never cleared except by reset; chain pass-through always works regardless of state.
- All registers are in the prog_clk domain; there are no latches and no combinational path from ccff_head to ccff_tail.

Test Plan:
- Reset with tile_o_in=10'h3FF: tile_o=0, cfg_valid=0, ccff_tail=0, shift_count=0, cfg_error=0. Asserting reset between edges clears outputs without waiting for a clock.
- NUM_SUBTILE=2, BITS_PER_SUBTILE=4 (T=8): shift 1,0,1,1,0,0,1,0 (first bit first).
  - Response: chain_full=1 on the 8th edge.
  - Pulse cfg_done: on the next edge cfg_bits=8'hB2, cfg_valid=1, tile_o=tile_o_in.
- From FULL after the above (before commit), 3 extra shifts of 1:
  - ccff_tail reads 1, then 0, then 1 on successive cycles.
  - shift_count stays 8 and chain_full stays 1.
- After reset, 5 shifts then a cfg_done pulse: cfg_error=1, cfg_valid=0, state IDLE, shift_count=0, tile_o=0.
- In ACTIVE with cfg_bits=8'hB2, shift 8'h5A and commit:
  - cfg_valid stays 1 and cfg_bits=8'hB2 throughout the shifting.
  - cfg_bits=8'h5A on the commit edge.
  - Repeating with only 3 shifts: cfg_error=1 and cfg_bits stays 8'h5A.
- cfg_en=1 held across the cfg_done rise cycle in FULL: no shift that cycle, and the committed value equals the pre-edge sreg.
